// File: rtl/sub_operand_sequencer.sv
// Captures X then Y from a shared bus on load edges and registers the subtractor result.
// Define SUB_BORROW_FLAG_EN to register an unsigned borrow flag alongside the result.
module sub_operand_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             clr,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    input  logic [WIDTH-1:0] res_in,
    output logic [WIDTH-1:0] result_q,
    output logic             borrow,
    output logic             busy,
    output logic             done,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_Y,
        CALC,
        DONE
    } state_t;

    state_t           state_q;
    logic             load_prev_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] res_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;
    logic             load_edge;

    assign load_edge = load & ~load_prev_q;
    assign cnt_d     = cnt_q + 8'd1;

    // load_prev resets high so a strobe held through reset release is not an edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            load_prev_q <= 1'b1;
            x_q         <= '0;
            y_q         <= '0;
            res_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            load_prev_q <= load;
            if (clr) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (load_edge) begin
                            x_q     <= din;
                            busy_q  <= 1'b1;
                            state_q <= WAIT_Y;
                        end
                    end
                    WAIT_Y: begin
                        if (load_edge) begin
                            y_q     <= din;
                            state_q <= CALC;
                        end
                    end
                    CALC: begin
                        res_q   <= res_in;
                        cnt_q   <= cnt_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                    DONE: begin
                        if (load_edge) begin
                            x_q     <= din;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            state_q <= WAIT_Y;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef SUB_BORROW_FLAG_EN
    logic borrow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            borrow_q <= 1'b0;
        end else if (!clr && state_q == CALC) begin
            borrow_q <= (x_q < y_q);
        end
    end

    assign borrow = borrow_q;
`else
    assign borrow = 1'b0;
`endif

    assign x_out    = x_q;
    assign y_out    = y_q;
    assign result_q = res_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign op_count = cnt_q;

endmodule
